proc_in_fifo: RTL and testbench

- Input-side buffer directly upstream of the Processor's 8-bit input port.
- Accepts bytes from a producer (switch/UART/host bench) on a simple write strobe and stores them in a circular FIFO.
- Presents the head byte to the Processor through the four-phase inDataReady/inACK handshake the Processor consumes.
- The Processor never stalls a producer and the producer never needs to know the handshake state.

---
 rtl/proc_in_fifo.sv | 126 ++++++++++++
 tb/tb_proc_in_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_in_fifo.sv
// Circular input FIFO feeding the Processor through a four-phase inDataReady/inACK handshake.
// Optional sticky overflow flag on dropped writes: define PROC_IN_FIFO_OVF_EN.
module proc_in_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wrData,
  input  logic             wrEn,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] in,
  output logic             inDataReady,
  input  logic             inACK
`ifdef PROC_IN_FIFO_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    RELEASE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic [WIDTH-1:0] r_in;
  logic             w_pop;
  logic             w_push;
  logic             w_load;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_empty) begin
          w_load      = 1'b1;
          w_state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (inACK) begin
          w_pop       = 1'b1;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!inACK) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A pop in the same edge frees a slot, so a write at full is still accepted.
  assign w_push = wrEn && (!r_full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_in    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      if (w_load) r_in    <= r_mem[r_rdPtr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= wrData;
  end

`ifdef PROC_IN_FIFO_OVF_EN
  logic r_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (wrEn && !w_push) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`endif

  assign full        = r_full;
  assign empty       = r_empty;
  assign count       = r_count;
  assign in          = r_in;
  assign inDataReady = (r_state == PRESENT);

endmodule

// File: tb/tb_proc_in_fifo.sv
// Self-checking bench for proc_in_fifo: queue-based reference model checked every cycle plus directed scenarios.
module tb_proc_in_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    wrData = '0;
  logic          wrEn = 1'b0;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [7:0]    dut_in;
  logic          inDataReady;
  logic          inACK = 1'b0;
`ifdef PROC_IN_FIFO_OVF_EN
  logic          overflow;
`endif

  proc_in_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .wrData(wrData),
    .wrEn(wrEn),
    .full(full),
    .empty(empty),
    .count(count),
    .in(dut_in),
    .inDataReady(inDataReady),
    .inACK(inACK)
`ifdef PROC_IN_FIFO_OVF_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: occupancy is the queue; the byte on offer stays in the queue until acked.
  logic [7:0] m_q[$];
  bit         m_rdy  = 1'b0;
  bit         m_wait = 1'b0;
  logic [7:0] m_in   = '0;

  always @(posedge clk or negedge reset) begin : model
    int n;
    bit pop;
    bit acc;
    bit load;
    if (!reset) begin
      m_q.delete();
      m_rdy  = 1'b0;
      m_wait = 1'b0;
      m_in   = '0;
    end else begin
      n    = m_q.size();
      pop  = m_rdy && inACK;
      acc  = wrEn && (n < DEPTH || pop);
      load = !m_rdy && !m_wait && n > 0;
      if (load) m_in = m_q[0];
      if (pop) begin
        void'(m_q.pop_front());
        m_rdy  = 1'b0;
        m_wait = 1'b1;
      end else if (load) begin
        m_rdy = 1'b1;
      end else if (m_wait && !inACK) begin
        m_wait = 1'b0;
      end
      if (acc) m_q.push_back(wrData);
    end
  end

  logic [7:0] rx[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(m_q.size()));
      check("full", 32'(full), 32'(m_q.size() == DEPTH));
      check("empty", 32'(empty), 32'(m_q.size() == 0));
      check("inDataReady", 32'(inDataReady), 32'(m_rdy));
      check("in", 32'(dut_in), 32'(m_in));
      if (reset && inDataReady && inACK) rx.push_back(dut_in);
    end
  end

  // mode 0: leave inACK alone, 1: prompt processor, 2: random processor with stray acks
  task automatic step(input bit we, input logic [7:0] d, input int mode);
    wrEn   = we;
    wrData = d;
    if (mode == 1) begin
      inACK = inDataReady;
    end else if (mode == 2) begin
      if (inDataReady && !inACK)       inACK = ($urandom_range(0, 2) == 0);
      else if (!inDataReady && inACK)  inACK = ($urandom_range(0, 1) == 0);
      else if (!inDataReady && !inACK) inACK = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      step(1'b0, 8'h00, 1);
      done = (m_q.size() == 0) && !m_rdy && !m_wait && !inACK;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    int idx;
    int cyc;
    bit we;

    #2 reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Reset then idle
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 8'h00, 0);
      check("idle_count", 32'(count), 32'd0);
      check("idle_empty", 32'(empty), 32'd1);
      check("idle_full", 32'(full), 32'd0);
      check("idle_rdy", 32'(inDataReady), 32'd0);
      check("idle_in", 32'(dut_in), 32'd0);
    end

    // Single byte
    step(1'b1, 8'hA5, 0);
    check("single_rdy_edgeN", 32'(inDataReady), 32'd0);
    check("single_count1", 32'(count), 32'd1);
    step(1'b0, 8'h00, 0);
    check("single_rdy_edgeN1", 32'(inDataReady), 32'd1);
    check("single_in", 32'(dut_in), 32'hA5);
    inACK = 1'b1;
    step(1'b0, 8'h00, 0);
    check("single_rdy_after_ack", 32'(inDataReady), 32'd0);
    check("single_count0", 32'(count), 32'd0);
    inACK = 1'b0;
    step(1'b0, 8'h00, 0);
    step(1'b0, 8'h00, 0);
    check("single_rdy_idle", 32'(inDataReady), 32'd0);

    // Order and wrap
    rx.delete();
    idx = 1;
    cyc = 0;
    while (rx.size() < 12 && cyc < 600) begin
      we = (idx <= 12) && (m_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
      step(we, 8'(idx), 2);
      if (we) idx++;
      cyc++;
    end
    check("order_rx_size", 32'(rx.size()), 32'd12);
    for (int i = 0; i < 12 && i < rx.size(); i++) check("order_byte", 32'(rx[i]), 32'(i + 1));
    drain("order_drain");

    // Full and drop
    inACK = 1'b0;
    for (int i = 0; i < 9; i++) step(1'b1, 8'(16 + i), 0);
    wrEn = 1'b0;
    check("full_flag", 32'(full), 32'd1);
    check("full_count", 32'(count), 32'd8);
    check("full_head", 32'(dut_in), 32'h10);
`ifdef PROC_IN_FIFO_OVF_EN
    check("full_overflow", 32'(overflow), 32'd1);
`endif
    rx.delete();
    drain("full_drain");
    check("full_rx_size", 32'(rx.size()), 32'd8);
    if (rx.size() == 8) begin
      check("full_first", 32'(rx[0]), 32'h10);
      check("full_last", 32'(rx[7]), 32'h17);
    end

    // Simultaneous write and pop at full
    for (int i = 0; i < 8; i++) step(1'b1, 8'(32 + i), 0);
    step(1'b0, 8'h00, 0);
    check("sim_count_pre", 32'(count), 32'd8);
    check("sim_rdy_pre", 32'(inDataReady), 32'd1);
    rx.delete();
    inACK = 1'b1;
    step(1'b1, 8'h55, 0);
    wrEn = 1'b0;
    check("sim_count_post", 32'(count), 32'd8);
    check("sim_full_post", 32'(full), 32'd1);
    drain("sim_drain");
    check("sim_rx_size", 32'(rx.size()), 32'd9);
    if (rx.size() == 9) begin
      check("sim_first", 32'(rx[0]), 32'h20);
      check("sim_last", 32'(rx[8]), 32'h55);
    end

    // Reset mid-handshake
    inACK = 1'b0;
    step(1'b1, 8'h31, 0);
    step(1'b1, 8'h32, 0);
    step(1'b1, 8'h33, 0);
    wrEn = 1'b0;
    check("rst_pre_count", 32'(count), 32'd3);
    check("rst_pre_rdy", 32'(inDataReady), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_rdy", 32'(inDataReady), 32'd0);
    check("rst_async_count", 32'(count), 32'd0);
    check("rst_async_empty", 32'(empty), 32'd1);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 8'h00, 0);
      check("rst_no_present", 32'(inDataReady), 32'd0);
    end

    // Random traffic
    for (int k = 0; k < 800; k++) step(1'($urandom_range(0, 1)), 8'($urandom), 2);
    drain("random_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
